// File: rtl/soc_pkg.sv
// ---------------------------------------------------------------------------
// soc_pkg
//   Shared types and default widths for the boot / bus controller slice.
//   - boot_state_e : controller state (boot read, boot write, arbitration)
//   - master_e     : identity of a RAM master (CPU or debug/DMA)
//   - ADDR_SIZE_DEF / WORD_SIZE_DEF : default bus widths (8 / 8)
// ---------------------------------------------------------------------------
package soc_pkg;

    localparam int ADDR_SIZE_DEF = 8;
    localparam int WORD_SIZE_DEF = 8;

    typedef enum logic [1:0] {
        BOOT_RD = 2'd0,
        BOOT_WR = 2'd1,
        ARB     = 2'd2
    } boot_state_e;

    typedef enum logic {
        M_CPU = 1'b0,
        M_DBG = 1'b1
    } master_e;

endpackage

// File: rtl/boot_bus_ctrl_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-requester round-robin arbiter. Grant is combinational in the request
//   cycle; the last-granted master is registered.
//   Ports:
//     clk, rst_n      : clock, async active-low reset
//     i_en            : arbitration enabled (no grants when low)
//     i_req_cpu/dbg   : requests
//     o_gnt_cpu/dbg   : one-hot (or zero) grants
//     o_rr_last       : last granted master (debug visibility)
// ---------------------------------------------------------------------------
module rr_arb2
    import soc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_req_cpu,
    input  logic i_req_dbg,
    output logic o_gnt_cpu,
    output logic o_gnt_dbg,
    output logic o_rr_last
);

    master_e r_rr_last;
    logic    w_gnt_cpu;
    logic    w_gnt_dbg;

    // On a tie, the master that did not win last time is served.
    always_comb begin
        w_gnt_cpu = i_en && i_req_cpu && (!i_req_dbg || (r_rr_last == M_DBG));
        w_gnt_dbg = i_en && i_req_dbg && (!i_req_cpu || (r_rr_last == M_CPU));
    end

    // Reset to DBG so the CPU wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last <= M_DBG;
        end else if (w_gnt_cpu) begin
            r_rr_last <= M_CPU;
        end else if (w_gnt_dbg) begin
            r_rr_last <= M_DBG;
        end
    end

    assign o_gnt_cpu = w_gnt_cpu;
    assign o_gnt_dbg = w_gnt_dbg;
    assign o_rr_last = r_rr_last;

endmodule

// File: rtl/boot_bus_ctrl.sv
// ---------------------------------------------------------------------------
// boot_bus_ctrl
//   Owner of the single RAM port. After reset copies BOOT_LEN words from ROM
//   into RAM at BOOT_BASE (one word per two cycles), raises o_boot_done, then
//   arbitrates single-cycle RAM accesses between CPU and debug/DMA masters.
//   Ports:
//     clk, rst_n                         : clock, async active-low reset
//     i_cpu_req/we/addr/wdata, o_cpu_gnt : CPU request, combinational grant
//     o_cpu_rdata, o_cpu_rvalid          : registered read return (1-cycle pulse)
//     i_dbg_*, o_dbg_*                   : same set for the debug/DMA master
//     o_rom_addr, i_rom_data             : ROM port (combinational read)
//     o_ram_addr/wdata/we, i_ram_rdata   : RAM port (comb read, write on edge)
//     o_boot_done                        : boot copy complete, sticky to reset
//     o_state                            : current controller state (debug)
//   Handshake: a master holds req/we/addr/wdata stable until it sees gnt in
//   the same cycle; the access completes at that cycle's rising edge and read
//   data appears with rvalid one cycle later. No grants outside ARB.
// ---------------------------------------------------------------------------
module boot_bus_ctrl
    import soc_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int BOOT_LEN  = 16,
    parameter int BOOT_BASE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_cpu_req,
    input  logic                 i_cpu_we,
    input  logic [ADDR_SIZE-1:0] i_cpu_addr,
    input  logic [WORD_SIZE-1:0] i_cpu_wdata,
    output logic                 o_cpu_gnt,
    output logic [WORD_SIZE-1:0] o_cpu_rdata,
    output logic                 o_cpu_rvalid,
    input  logic                 i_dbg_req,
    input  logic                 i_dbg_we,
    input  logic [ADDR_SIZE-1:0] i_dbg_addr,
    input  logic [WORD_SIZE-1:0] i_dbg_wdata,
    output logic                 o_dbg_gnt,
    output logic [WORD_SIZE-1:0] o_dbg_rdata,
    output logic                 o_dbg_rvalid,
    output logic [ADDR_SIZE-1:0] o_rom_addr,
    input  logic [WORD_SIZE-1:0] i_rom_data,
    output logic [ADDR_SIZE-1:0] o_ram_addr,
    output logic [WORD_SIZE-1:0] o_ram_wdata,
    output logic                 o_ram_we,
    input  logic [WORD_SIZE-1:0] i_ram_rdata,
    output logic                 o_boot_done,
    output logic [1:0]           o_state
);

    localparam int IDX_W = $clog2(BOOT_LEN + 1);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(BOOT_LEN - 1);
    localparam logic [ADDR_SIZE-1:0] BASE_A   = ADDR_SIZE'(BOOT_BASE);

    boot_state_e          r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [WORD_SIZE-1:0] r_boot_buf;
    logic                 r_boot_done;
    logic [WORD_SIZE-1:0] r_cpu_rdata;
    logic                 r_cpu_rvalid;
    logic [WORD_SIZE-1:0] r_dbg_rdata;
    logic                 r_dbg_rvalid;

    logic                 w_gnt_cpu;
    logic                 w_gnt_dbg;
    logic                 w_rr_last;
    logic [ADDR_SIZE-1:0] w_idx_addr;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (r_state == ARB),
        .i_req_cpu (i_cpu_req),
        .i_req_dbg (i_dbg_req),
        .o_gnt_cpu (w_gnt_cpu),
        .o_gnt_dbg (w_gnt_dbg),
        .o_rr_last (w_rr_last)
    );

    // Boot index mapped onto the address bus (truncates when BOOT_LEN spans
    // the whole address space).
    assign w_idx_addr = ADDR_SIZE'(r_idx);

    // Boot / arbitration FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= BOOT_RD;
            r_idx       <= '0;
            r_boot_buf  <= '0;
            r_boot_done <= 1'b0;
        end else begin
            case (r_state)
                BOOT_RD: begin
                    r_boot_buf <= i_rom_data;
                    r_state    <= BOOT_WR;
                end
                BOOT_WR: begin
                    if (r_idx == LAST_IDX) begin
                        r_state     <= ARB;
                        r_boot_done <= 1'b1;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= BOOT_RD;
                    end
                end
                ARB:     r_state <= ARB;
                default: r_state <= BOOT_RD;
            endcase
        end
    end

    // Read return: capture RAM data on the granted master's read edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_rdata  <= '0;
            r_cpu_rvalid <= 1'b0;
            r_dbg_rdata  <= '0;
            r_dbg_rvalid <= 1'b0;
        end else begin
            r_cpu_rvalid <= w_gnt_cpu && !i_cpu_we;
            r_dbg_rvalid <= w_gnt_dbg && !i_dbg_we;
            if (w_gnt_cpu && !i_cpu_we) r_cpu_rdata <= i_ram_rdata;
            if (w_gnt_dbg && !i_dbg_we) r_dbg_rdata <= i_ram_rdata;
        end
    end

    // RAM port mux: boot writer, else the granted master, else idle.
    always_comb begin
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        o_ram_we    = 1'b0;
        if (r_state == BOOT_WR) begin
            o_ram_addr  = BASE_A + w_idx_addr;
            o_ram_wdata = r_boot_buf;
            o_ram_we    = 1'b1;
        end else if (w_gnt_cpu) begin
            o_ram_addr  = i_cpu_addr;
            o_ram_wdata = i_cpu_wdata;
            o_ram_we    = i_cpu_we;
        end else if (w_gnt_dbg) begin
            o_ram_addr  = i_dbg_addr;
            o_ram_wdata = i_dbg_wdata;
            o_ram_we    = i_dbg_we;
        end
    end

    assign o_rom_addr   = (r_state == BOOT_RD) ? w_idx_addr : '0;
    assign o_cpu_gnt    = w_gnt_cpu;
    assign o_dbg_gnt    = w_gnt_dbg;
    assign o_cpu_rdata  = r_cpu_rdata;
    assign o_cpu_rvalid = r_cpu_rvalid;
    assign o_dbg_rdata  = r_dbg_rdata;
    assign o_dbg_rvalid = r_dbg_rvalid;
    assign o_boot_done  = r_boot_done;
    assign o_state      = r_state;

    // Arbiter history is only observable inside rr_arb2.
    logic w_unused;
    assign w_unused = w_rr_last;

endmodule

// File: tb/tb_boot_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_boot_bus_ctrl
//   Directed bench for boot_bus_ctrl with behavioural ROM/RAM models.
// ---------------------------------------------------------------------------
module tb_boot_bus_ctrl;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT signals
    logic       cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0] cpu_addr = 8'h00, cpu_wdata = 8'h00;
    logic       cpu_gnt, cpu_rvalid;
    logic [7:0] cpu_rdata;
    logic       dbg_req = 1'b0, dbg_we = 1'b0;
    logic [7:0] dbg_addr = 8'h00, dbg_wdata = 8'h00;
    logic       dbg_gnt, dbg_rvalid;
    logic [7:0] dbg_rdata;
    logic [7:0] rom_addr, rom_data;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;
    logic       ram_we, boot_done;
    logic [1:0] state;

    // Memory models
    logic [7:0] rom_mem [256];
    logic [7:0] ram_mem [256] = '{default: 8'h00};
    assign rom_data  = rom_mem[rom_addr];
    assign ram_rdata = ram_mem[ram_addr];
    always @(posedge clk) if (ram_we) ram_mem[ram_addr] <= ram_wdata;

    boot_bus_ctrl #(.ADDR_SIZE(8), .WORD_SIZE(8), .BOOT_LEN(16), .BOOT_BASE(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cpu_req    (cpu_req),
        .i_cpu_we     (cpu_we),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wdata  (cpu_wdata),
        .o_cpu_gnt    (cpu_gnt),
        .o_cpu_rdata  (cpu_rdata),
        .o_cpu_rvalid (cpu_rvalid),
        .i_dbg_req    (dbg_req),
        .i_dbg_we     (dbg_we),
        .i_dbg_addr   (dbg_addr),
        .i_dbg_wdata  (dbg_wdata),
        .o_dbg_gnt    (dbg_gnt),
        .o_dbg_rdata  (dbg_rdata),
        .o_dbg_rvalid (dbg_rvalid),
        .o_rom_addr   (rom_addr),
        .i_rom_data   (rom_data),
        .o_ram_addr   (ram_addr),
        .o_ram_wdata  (ram_wdata),
        .o_ram_we     (ram_we),
        .i_ram_rdata  (ram_rdata),
        .o_boot_done  (boot_done),
        .o_state      (state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_rom(input logic [7:0] base);
        for (int i = 0; i < 256; i++) rom_mem[i] = base + 8'(i);
    endtask

    // Counts edges from reset release; boot_done must rise exactly after edge 32
    // and no master may be granted before it.
    task automatic wait_boot();
        for (int e = 1; e <= 32; e++) begin
            @(posedge clk); #1;
            if (e < 32) begin
                check($sformatf("boot_done_low_e%0d", e), 32'(boot_done), 32'd0);
                check($sformatf("no_gnt_e%0d", e), 32'({cpu_gnt, dbg_gnt}), 32'd0);
            end else begin
                check("boot_done_e32", 32'(boot_done), 32'd1);
            end
        end
    endtask

    task automatic check_ram(input logic [7:0] base);
        for (int i = 0; i < 16; i++)
            check($sformatf("ram_%0d", i), 32'(ram_mem[i]), 32'(8'(base + 8'(i))));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int cpu_n;
        int dbg_n;
        load_rom(8'hA0);
        // CPU write request held from reset through boot.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 8'h55;
        #12;
        check("rst_state", 32'(state), 32'd0);
        check("rst_boot_done", 32'(boot_done), 32'd0);
        check("rst_gnt", 32'({cpu_gnt, dbg_gnt}), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_rvalid", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
        check("rst_rdata", 32'({cpu_rdata, dbg_rdata}), 32'd0);

        @(negedge clk); rst_n = 1'b1;
        wait_boot();
        check_ram(8'hA0);
        // First ARB cycle: CPU granted, its write not yet in RAM.
        check("cpu_first_gnt", 32'(cpu_gnt), 32'd1);
        check("cpu_wr_we", 32'(ram_we), 32'd1);
        check("ram40_before", 32'(ram_mem[8'h40]), 32'd0);
        @(posedge clk); #1;
        check("ram40_written", 32'(ram_mem[8'h40]), 32'h55);
        cpu_we = 1'b0;
        #1;
        check("cpu_rd_gnt", 32'(cpu_gnt), 32'd1);
        check("cpu_rd_we", 32'(ram_we), 32'd0);
        @(posedge clk); #1;
        check("cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        check("cpu_rdata", 32'(cpu_rdata), 32'h55);
        cpu_req = 1'b0;
        @(posedge clk); #1;
        check("cpu_rvalid_pulse", 32'(cpu_rvalid), 32'd0);
        check("cpu_rdata_hold", 32'(cpu_rdata), 32'h55);

        // Lone DBG writer: granted every cycle.
        dbg_req = 1'b1; dbg_we = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dbg_addr = 8'h80 + 8'(k); dbg_wdata = 8'h60 + 8'(k);
            #1;
            check($sformatf("dbg_lone_gnt%0d", k), 32'({cpu_gnt, dbg_gnt}), 32'd1);
            @(posedge clk); #1;
        end
        dbg_req = 1'b0; dbg_we = 1'b0;
        for (int k = 0; k < 4; k++)
            check($sformatf("dbg_wr_%0d", k), 32'(ram_mem[8'h80 + 8'(k)]), 32'(8'h60 + 8'(k)));

        // Contention: both read continuously; CPU first since DBG won last.
        cpu_n = 0; dbg_n = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h00;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h80;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("cont_cpu_gnt%0d", k), 32'(cpu_gnt), 32'((k % 2) == 0));
            check($sformatf("cont_dbg_gnt%0d", k), 32'(dbg_gnt), 32'((k % 2) == 1));
            @(posedge clk); #1;
            if ((k % 2) == 0) begin
                check($sformatf("cont_cpu_rv%0d", k), 32'({cpu_rvalid, dbg_rvalid}), 32'd2);
                check($sformatf("cont_cpu_rd%0d", k), 32'(cpu_rdata), 32'(8'hA0 + 8'(cpu_n)));
                cpu_n++;
                cpu_addr = 8'(cpu_n);
            end else begin
                check($sformatf("cont_dbg_rv%0d", k), 32'({cpu_rvalid, dbg_rvalid}), 32'd1);
                check($sformatf("cont_dbg_rd%0d", k), 32'(dbg_rdata), 32'(8'h60 + 8'(dbg_n)));
                dbg_n++;
                dbg_addr = 8'h80 + 8'(dbg_n);
            end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;

        // Reset mid-boot after word 5 (edge 12), then re-boot with a new ROM.
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
        end
        check("mid_ram5", 32'(ram_mem[5]), 32'hA5);
        check("mid_state", 32'(state), 32'd0);
        rst_n = 1'b0;
        load_rom(8'h10);
        #1;
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_we", 32'(ram_we), 32'd0);
        check("mid_rst_done", 32'(boot_done), 32'd0);
        check("mid_rst_rdata", 32'({cpu_rdata, dbg_rdata}), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        wait_boot();
        check_ram(8'h10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/boot_bus_ctrl.md
# boot_bus_ctrl

Controller that owns the SoC's single RAM port. Out of reset it copies the boot image from ROM into RAM, one word per two cycles, then raises `boot_done`. After that it arbitrates single-cycle RAM accesses between the CPU and a debug/DMA requester using round-robin. It sits between the masters (CPU, debug port) and the `ram`/`rom` blocks and replaces direct CPU drive of the shared address/data buses.

## Interface
- `ADDR_SIZE`, 8: address width.
- `WORD_SIZE`, 8: data width.
- `BOOT_LEN`, 16: words copied at boot, range 1..2^ADDR_SIZE.
- `BOOT_BASE`, 0: RAM address receiving ROM word 0.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpu_req`, `cpu_we`  in  1  CPU access request / write enable.
- `cpu_addr`  in  ADDR_SIZE  CPU address.
- `cpu_wdata`  in  WORD_SIZE  CPU write data.
- `cpu_gnt`  out  1  access performed this cycle (combinational).
- `cpu_rdata`  out  WORD_SIZE  registered read data.
- `cpu_rvalid`  out  1  `cpu_rdata` valid, one-cycle pulse.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rdata`, `dbg_rvalid`: same as CPU set.
- `rom_addr`  out  ADDR_SIZE  ROM address; ROM read is combinational.
- `rom_data`  in  WORD_SIZE  ROM word.
- `ram_addr`  out  ADDR_SIZE  RAM address.
- `ram_wdata`  out  WORD_SIZE  RAM write data.
- `ram_we`  out  1  RAM write strobe; RAM writes on the rising edge.
- `ram_rdata`  in  WORD_SIZE  RAM read data, combinational from `ram_addr`.
- `boot_done`  out  1  boot copy complete; stays high until reset.

## Operation
- States: `BOOT_RD`, `BOOT_WR`, `ARB`. The reset state is `BOOT_RD`.
- Boot index `idx` is a counter of width `$clog2(BOOT_LEN+1)`. It resets to 0.
- `BOOT_RD`:
  - Drive `rom_addr = idx`.
  - Latch `rom_data` into `boot_buf`.
  - Go to `BOOT_WR`.
- `BOOT_WR`:
  - Drive `ram_addr = BOOT_BASE + idx` (mod 2^ADDR_SIZE, wraps silently) and `ram_wdata = boot_buf`, with `ram_we = 1`.
  - If `idx == BOOT_LEN-1`, go to `ARB` and set `boot_done`.
  - Otherwise increment `idx` and go to `BOOT_RD`.
- `ARB`:
  - The `rr_last` flag records the last granted master. Its reset value is DBG, so the CPU wins the first tie.
  - If only one master requests, that master is granted.
  - If both request, the master not equal to `rr_last` is granted. Update `rr_last` on every grant.
  - If neither requests, no grant.
- The granted master's address, write enable and write data are muxed combinationally onto `ram_*`. The access completes at that cycle's rising edge.
- On a granted read, `ram_rdata` is registered into `<m>_rdata`, and `<m>_rvalid` pulses in the next cycle. `<m>_rdata` holds its value otherwise.
- While not in `ARB`, both `gnt` outputs are 0 and requests are ignored (not queued).
- Masters hold `req`/`addr`/`we`/`wdata` stable until they see `gnt`. They may present the next request in the cycle following a grant.
- Idle drive values: `ram_we = 0` whenever there is no write. `ram_addr`/`ram_wdata` are don't-care when `ram_we = 0` and there is no read grant. `rom_addr = 0` outside `BOOT_RD`.

## Timing
- Reset values: state `BOOT_RD`, `idx = 0`, `boot_buf = 0`, `boot_done = 0`, `rr_last = DBG`, `*_rdata = 0`, `*_rvalid = 0`. While reset is low, `ram_we = 0` and both `gnt = 0`.
- Boot write schedule: count rising edges after `rst_n` is released. Word i is written at edge 2i+2, and `boot_done` rises after edge 2·BOOT_LEN (32 edges for the default).
- Grant is combinational in the request cycle. Read data arrives 1 cycle after the grant.
- Throughput:
  - A lone requester gets one grant per cycle.
  - Two persistent requesters alternate CPU, DBG, CPU, and so on.
- Reset mid-boot or mid-access aborts immediately (asynchronously). The boot copy restarts from `idx = 0`.
- Simultaneous write and read of the same address by different masters is impossible: only one grant is given per cycle.

## Structure
- Shared package `soc_pkg` holds:
  - the state enum `boot_state_e`;
  - the master-id enum (`M_CPU`, `M_DBG`);
  - the default width constants, consistent with the existing `ADDR_SIZE`/`WORD_SIZE` macros.
- Sub-module `rr_arb2`: two-requester round-robin arbiter with combinational grant and registered `rr_last`. The remainder (boot FSM, mux, read-return registers) stays in `boot_bus_ctrl`.

## Test plan
- **Boot copy:** ROM[i] = 0xA0+i, `BOOT_LEN` = 16, `rst_n` released. Required: RAM[0..15] = 0xA0..0xAF, `boot_done` rises after edge 32, and no `cpu_gnt`/`dbg_gnt` before that.
- **Request during boot:** `cpu_req` held from reset. Required: first `cpu_gnt` occurs in the first cycle with `boot_done` = 1, and no earlier RAM write from the CPU.
- **CPU write then read:** CPU writes 0x55 to 0x40, then reads 0x40. Required: `cpu_gnt` in each request cycle, and `cpu_rdata` = 0x55 with `cpu_rvalid` pulsing one cycle after the read grant.
- **Contention:** both masters request continuously for 6 cycles after boot. Required: grants CPU, DBG, CPU, DBG, CPU, DBG; `dbg_rdata` returns DBG's addresses only.
- **Lone requester:** only DBG requests for 4 cycles. Required: `dbg_gnt` is high all 4 cycles.
- **Reset mid-boot:** `rst_n` pulled low after word 5 is written, with ROM changed to 0x10+i. Required: outputs reset immediately, RAM[0..15] = 0x10..0x1F after re-boot, and `boot_done` rises 32 edges after the second release.
